// File: rtl/pe_dbw.sv
// Systolic MAC processing element with a double-buffered weight bank (WS mode)
// and a local accumulator drained down the sum chain (OS mode).
module pe_dbw #(
  parameter int A_W   = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             MODE,
  input  logic             SWAP,
  input  logic             W_EN,
  input  logic             DRAIN,
  input  logic [A_W-1:0]   a_in,
  input  logic             a_vld_in,
  output logic [A_W-1:0]   a_out,
  output logic             a_vld_out,
  input  logic [W_W-1:0]   w_in,
  output logic [W_W-1:0]   w_out,
  input  logic [ACC_W-1:0] sum_in,
  input  logic             sum_vld_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_vld_out
);

  localparam int P_W = A_W + W_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [W_W-1:0]   bank0, bank1;
  logic             bank_ptr;
  logic [ACC_W-1:0] acc;

  logic [W_W-1:0]   active_w, mul_w;
  logic [P_W-1:0]   a_ext, w_ext, prod;
  logic [ACC_W-1:0] prod_ext, ws_sum, os_sum;
  logic             os_acc_en;

  // Signed add in ACC_W+1 bits; overflow shows as disagreement of the top two bits.
  function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (SAT && (s[ACC_W] != s[ACC_W-1]))
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign active_w  = bank_ptr ? bank1 : bank0;
  assign mul_w     = MODE ? w_in : active_w;
  assign a_ext     = {{W_W{a_in[A_W-1]}}, a_in};
  assign w_ext     = {{A_W{mul_w[W_W-1]}}, mul_w};
  assign prod      = a_ext * w_ext;
  assign prod_ext  = ACC_W'($signed(prod));
  assign ws_sum    = add_acc(sum_in, prod_ext);
  assign os_sum    = add_acc(acc, prod_ext);
  assign os_acc_en = a_vld_in & W_EN;

  // Valid-only chain, no backpressure: a_vld/sum_vld travel with their data one
  // stage per enabled edge, and a cleared valid marks a bubble that still moves.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_out       <= '0;
      a_vld_out   <= 1'b0;
      w_out       <= '0;
      sum_out     <= '0;
      sum_vld_out <= 1'b0;
      bank0       <= '0;
      bank1       <= '0;
      bank_ptr    <= 1'b0;
      acc         <= '0;
    end else if (EN) begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      if (W_EN) w_out <= w_in;
      if (!MODE) begin
        // The write lands in the pre-swap shadow, which becomes active after this edge.
        if (W_EN) begin
          if (bank_ptr) bank0 <= w_in;
          else          bank1 <= w_in;
        end
        if (SWAP) bank_ptr <= ~bank_ptr;
        sum_out     <= a_vld_in ? ws_sum : sum_in;
        sum_vld_out <= sum_vld_in;
      end else if (DRAIN) begin
        sum_out     <= acc;
        sum_vld_out <= 1'b1;
        acc         <= os_acc_en ? prod_ext : '0;
      end else begin
        sum_out     <= sum_in;
        sum_vld_out <= sum_vld_in;
        if (os_acc_en) acc <= os_sum;
      end
    end
  end

endmodule

// File: tb/tb_pe_dbw.sv
// Bench for pe_dbw: saturating and wrapping instances share stimulus; directed
// vector table, hand-written EN/hold sequence, then randomized model comparison.
module tb_pe_dbw;
  localparam int A_W   = 8;
  localparam int W_W   = 8;
  localparam int ACC_W = 16;
  localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
  localparam int MINV  = -(1 << (ACC_W - 1));

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic EN, MODE, SWAP, W_EN, DRAIN, a_vld_in, sum_vld_in;
  logic [A_W-1:0]   a_in;
  logic [W_W-1:0]   w_in;
  logic [ACC_W-1:0] sum_in;

  logic [A_W-1:0]   a_out_s, a_out_w;
  logic             a_vld_out_s, a_vld_out_w;
  logic [W_W-1:0]   w_out_s, w_out_w;
  logic [ACC_W-1:0] sum_out_s, sum_out_w;
  logic             sum_vld_out_s, sum_vld_out_w;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  pe_dbw #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .SAT(1'b1)) u_sat (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .SWAP(SWAP), .W_EN(W_EN),
    .DRAIN(DRAIN), .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out_s),
    .a_vld_out(a_vld_out_s), .w_in(w_in), .w_out(w_out_s), .sum_in(sum_in),
    .sum_vld_in(sum_vld_in), .sum_out(sum_out_s), .sum_vld_out(sum_vld_out_s));

  pe_dbw #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .SAT(1'b0)) u_wrap (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .SWAP(SWAP), .W_EN(W_EN),
    .DRAIN(DRAIN), .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out_w),
    .a_vld_out(a_vld_out_w), .w_in(w_in), .w_out(w_out_w), .sum_in(sum_in),
    .sum_vld_in(sum_vld_in), .sum_out(sum_out_w), .sum_vld_out(sum_vld_out_w));

  // ---------------- reference model (index 1 = saturating, 0 = wrapping) ----------------
  int m_bank[2];
  int m_ptr;
  int m_acc[2];
  int m_a, m_av, m_w;
  int m_s[2];
  int m_sv[2];
  logic [ACC_W-1:0] exp_q[$];

  function automatic int fix(int v, int sat);
    logic [ACC_W-1:0] t;
    if (sat != 0) begin
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
    end
    t = v[ACC_W-1:0];
    return int'($signed(t));
  endfunction

  task automatic model_reset();
    m_bank[0] = 0; m_bank[1] = 0; m_ptr = 0;
    m_a = 0; m_av = 0; m_w = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_s[k] = 0; m_sv[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    int a, w, s, p;
    a = int'($signed(a_in));
    w = int'($signed(w_in));
    s = int'($signed(sum_in));
    if (EN) begin
      m_a  = a;
      m_av = int'(a_vld_in);
      if (W_EN) m_w = w;
      if (!MODE) begin
        p = m_bank[m_ptr] * a;
        for (int k = 0; k < 2; k++) begin
          m_s[k]  = a_vld_in ? fix(s + p, k) : s;
          m_sv[k] = int'(sum_vld_in);
        end
        if (W_EN) m_bank[1 - m_ptr] = w;
        if (SWAP) m_ptr = 1 - m_ptr;
      end else begin
        p = w * a;
        for (int k = 0; k < 2; k++) begin
          if (DRAIN) begin
            m_s[k]   = m_acc[k];
            m_sv[k]  = 1;
            m_acc[k] = (a_vld_in && W_EN) ? p : 0;
          end else begin
            m_s[k]  = s;
            m_sv[k] = int'(sum_vld_in);
            if (a_vld_in && W_EN) m_acc[k] = fix(m_acc[k] + p, k);
          end
        end
      end
    end
    exp_q.push_back(ACC_W'(m_s[1]));
    exp_q.push_back(ACC_W'(m_s[0]));
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [ACC_W-1:0] e_sat, e_wrap;
    if (exp_q.size() < 2) begin
      chk("exp_q_depth", exp_q.size(), 2);
      return;
    end
    e_sat  = exp_q.pop_front();
    e_wrap = exp_q.pop_front();
    chk("m_sum_sat",  int'($signed(sum_out_s)), int'($signed(e_sat)));
    chk("m_sum_wrap", int'($signed(sum_out_w)), int'($signed(e_wrap)));
    chk("m_sum_vld_sat",  int'(sum_vld_out_s), m_sv[1]);
    chk("m_sum_vld_wrap", int'(sum_vld_out_w), m_sv[0]);
    chk("m_a_out",  int'($signed(a_out_s)), m_a);
    chk("m_a_vld",  int'(a_vld_out_s), m_av);
    chk("m_w_out",  int'($signed(w_out_s)), m_w);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic mode, input logic swap,
                       input logic wen, input logic drain, input int a,
                       input logic av, input int w, input int s, input logic sv);
    EN = en; MODE = mode; SWAP = swap; W_EN = wen; DRAIN = drain;
    a_in = A_W'(a); a_vld_in = av; w_in = W_W'(w);
    sum_in = ACC_W'(s); sum_vld_in = sv;
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    drive(1, 1, 1, 1, 1, 37, 1, -5, 1000, 1);
    @(negedge CLK);
    RESET = 1'b0;
    #2;
    chk("rst_a_out",   int'(a_out_s), 0);
    chk("rst_a_vld",   int'(a_vld_out_s), 0);
    chk("rst_w_out",   int'(w_out_s), 0);
    chk("rst_sum_sat", int'(sum_out_s), 0);
    chk("rst_sum_wrp", int'(sum_out_w), 0);
    chk("rst_sum_vld", int'(sum_vld_out_s), 0);
    model_reset();
    @(posedge CLK);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic mode, swap, wen, drain;
    int   a;
    logic av;
    int   w;
    int   s;
    logic sv;
    int   exp_sat, exp_wrap;
    logic exp_sv;
    int   exp_w;
  } vec_t;

  function automatic vec_t mk(input logic mode, input logic swap, input logic wen,
                              input logic drain, input int a, input logic av,
                              input int w, input int s, input logic sv,
                              input int es, input int ew, input logic esv,
                              input int eww);
    vec_t v;
    v.mode = mode; v.swap = swap; v.wen = wen; v.drain = drain;
    v.a = a; v.av = av; v.w = w; v.s = s; v.sv = sv;
    v.exp_sat = es; v.exp_wrap = ew; v.exp_sv = esv; v.exp_w = eww;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //             md sw we dr  a   av  w     s     sv  sat     wrap   esv  w_out
    tbl.push_back(mk(0, 1, 0, 0, 5,   1, 0,    0,     0, 0,      0,      0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5,   1, 0,    0,     0, 0,      0,      0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0, 3,    0,     0, 0,      0,      0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0,    0,     0, 0,      0,      0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 5,   1, 0,    10,    1, 25,     25,     1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 4,   1, -2,   0,     1, 12,     12,     1, -2));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0,    0,     0, 0,      0,      0, -2));
    tbl.push_back(mk(0, 0, 0, 0, 4,   1, 0,    0,     0, -8,     -8,     0, -2));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0,    0,     0, 0,      0,      0, -2));
    tbl.push_back(mk(0, 1, 1, 0, 1,   1, 7,    0,     0, 3,      3,      0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 1,   1, 0,    0,     0, 7,      7,      0, 7));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0, 127,  0,     0, 0,      0,      0, 127));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0,    0,     0, 0,      0,      0, 127));
    tbl.push_back(mk(0, 0, 0, 0, 127, 1, 0,    32760, 1, 32767,  -16647, 1, 127));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0, -128, 0,     0, 0,      0,      0, -128));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0, 0,    0,     0, 0,      0,      0, -128));
    tbl.push_back(mk(0, 0, 0, 0, 127, 1, 0,   -32760, 1, -32768, 16520,  1, -128));
    tbl.push_back(mk(0, 0, 0, 0, 9,   0, 0,    1234,  1, 1234,   1234,   1, -128));
    tbl.push_back(mk(0, 0, 0, 0, 1,   1, 0,    5,     0, -123,   -123,   0, -128));
    tbl.push_back(mk(1, 0, 1, 0, 1,   1, 2,    0,     0, 0,      0,      0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 2,   1, 2,    0,     0, 0,      0,      0, 2));
    tbl.push_back(mk(1, 1, 1, 0, 3,   1, 2,    0,     0, 0,      0,      0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0,    99,    0, 12,     12,     1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0, 0,    99,    1, 99,     99,     1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0,    0,     0, 0,      0,      1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 5,   1, 5,    0,     0, 0,      0,      0, 5));
    tbl.push_back(mk(1, 0, 1, 1, 4,   1, 3,    0,     0, 25,     25,     1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0,    0,     0, 12,     12,     1, 3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 1, 0, 127, 1, 127, 0,   0, 0,      0,      0, 127));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0,    0,     0, 32767,  -17149, 1, 127));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 1, 0, 127, 1, -128, 0,  0, 0,      0,      0, -128));
    tbl.push_back(mk(1, 0, 0, 1, 0,   0, 0,    0,     0, -32768, 16768,  1, -128));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1, tbl[i].mode, tbl[i].swap, tbl[i].wen, tbl[i].drain, tbl[i].a,
            tbl[i].av, tbl[i].w, tbl[i].s, tbl[i].sv);
      step();
      chk($sformatf("tbl%0d_sum_sat", i),  int'($signed(sum_out_s)), tbl[i].exp_sat);
      chk($sformatf("tbl%0d_sum_wrap", i), int'($signed(sum_out_w)), tbl[i].exp_wrap);
      chk($sformatf("tbl%0d_sum_vld", i),  int'(sum_vld_out_s), int'(tbl[i].exp_sv));
      chk($sformatf("tbl%0d_w_out", i),    int'($signed(w_out_s)), tbl[i].exp_w);
    end

    // OS accumulate, stall two cycles with busy inputs, then drain.
    drive(1, 1, 0, 1, 0, 3, 1, 4, 0, 0);
    step();
    chk("hold_pre_a_out", int'($signed(a_out_s)), 3);
    chk("hold_pre_w_out", int'($signed(w_out_s)), 4);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 1, 1, 7, 0, 9, 55, 1);
      step();
      chk("hold_a_out",   int'($signed(a_out_s)), 3);
      chk("hold_a_vld",   int'(a_vld_out_s), 1);
      chk("hold_w_out",   int'($signed(w_out_s)), 4);
      chk("hold_sum",     int'($signed(sum_out_s)), 0);
      chk("hold_sum_vld", int'(sum_vld_out_s), 0);
    end
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    step();
    chk("hold_drain_sat",  int'($signed(sum_out_s)), 12);
    chk("hold_drain_wrap", int'($signed(sum_out_w)), 12);
    chk("hold_drain_vld",  int'(sum_vld_out_s), 1);

    // Randomized WS then OS runs; reset between them discards in-flight data.
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        int s;
        case ($urandom_range(0, 3))
          0:       s = MAXV - int'($urandom_range(0, 200));
          1:       s = MINV + int'($urandom_range(0, 200));
          default: s = int'($urandom_range(0, 65535)) - 32768;
        endcase
        drive($urandom_range(0, 9) != 0, ph[0], $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
              int'($urandom_range(0, 255)) - 128, $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 255)) - 128, s, $urandom_range(0, 1) == 1);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
